// File: rtl/bus_read_sequencer_if.sv
// Command/response channel between the read sequencer (master) and one
// serial-bus initiator (slave).
interface bus_read_sequencer_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 8
);
    logic                  init_ready;
    logic                  init_req;
    logic                  init_mode;
    logic [ADDR_WIDTH-1:0] init_addr;
    logic [DATA_WIDTH-1:0] init_rdata;
    logic                  init_rdata_valid;

    modport master (
        input  init_ready,
        input  init_rdata,
        input  init_rdata_valid,
        output init_req,
        output init_mode,
        output init_addr
    );

    modport slave (
        output init_ready,
        output init_rdata,
        output init_rdata_valid,
        input  init_req,
        input  init_mode,
        input  init_addr
    );
endinterface

// File: rtl/bus_read_sequencer.sv
// Debounced trigger -> one read from a circular buffer in the target's address
// space; the returned word is shown on the LEDs and the buffer pointer advances.
module bus_read_sequencer #(
    parameter int ADDR_WIDTH      = 12,
    parameter int DATA_WIDTH      = 8,
    parameter int BASE_ADDR       = 0,
    parameter int BUF_DEPTH       = 6,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int TIMEOUT_CYCLES  = 1023
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         trigger,
    bus_read_sequencer_if.master         bus,
    output logic [DATA_WIDTH-1:0]        leds,
    output logic                         busy,
    output logic                         timeout_err,
    output logic [$clog2(BUF_DEPTH)-1:0] buf_ptr
);
    localparam int PTR_WIDTH  = $clog2(BUF_DEPTH);
    localparam int DEB_WIDTH  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int WAIT_WIDTH = $clog2(TIMEOUT_CYCLES);

    localparam logic [DEB_WIDTH-1:0]  DEB_MAX   = DEB_WIDTH'(DEBOUNCE_CYCLES);
    localparam logic [DEB_WIDTH-1:0]  DEB_LAST  = DEB_WIDTH'(DEBOUNCE_CYCLES - 1);
    localparam logic [WAIT_WIDTH-1:0] WAIT_LAST = WAIT_WIDTH'(TIMEOUT_CYCLES - 1);
    localparam logic [PTR_WIDTH-1:0]  PTR_LAST  = PTR_WIDTH'(BUF_DEPTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

    state_t                state_q, state_d;
    logic                  sync1_q, sync2_q;
    logic [DEB_WIDTH-1:0]  deb_cnt_q, deb_cnt_d;
    logic                  trig_pulse_q, trig_pulse_d;
    logic                  pending_q, pending_d;
    logic [WAIT_WIDTH-1:0] wait_cnt_q, wait_cnt_d;
    logic [PTR_WIDTH-1:0]  ptr_q, ptr_d;
    logic [DATA_WIDTH-1:0] leds_q, leds_d;
    logic                  timeout_q, timeout_d;
    logic                  busy_q, busy_d;
    logic                  req_q, req_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;

    // Counter saturates at DEB_MAX, so a held button yields a single pulse.
    always_comb begin
        deb_cnt_d    = deb_cnt_q;
        trig_pulse_d = 1'b0;
        if (!sync2_q) begin
            deb_cnt_d = '0;
        end else if (deb_cnt_q != DEB_MAX) begin
            deb_cnt_d    = deb_cnt_q + 1'b1;
            trig_pulse_d = (deb_cnt_q == DEB_LAST);
        end
    end

    always_comb begin
        state_d    = state_q;
        pending_d  = pending_q | trig_pulse_q;
        wait_cnt_d = wait_cnt_q;
        ptr_d      = ptr_q;
        leds_d     = leds_q;
        timeout_d  = timeout_q;
        addr_d     = addr_q;
        case (state_q)
            S_IDLE: begin
                if ((pending_q | trig_pulse_q) && bus.init_ready) begin
                    state_d   = S_REQ;
                    pending_d = 1'b0;
                    addr_d    = ADDR_WIDTH'(BASE_ADDR) + ADDR_WIDTH'(ptr_q);
                end
            end
            S_REQ: begin
                state_d    = S_WAIT;
                wait_cnt_d = '0;
            end
            S_WAIT: begin
                // A response arriving on the last wait cycle still counts as success.
                if (bus.init_rdata_valid) begin
                    state_d   = S_IDLE;
                    leds_d    = bus.init_rdata;
                    ptr_d     = (ptr_q == PTR_LAST) ? '0 : ptr_q + 1'b1;
                    timeout_d = 1'b0;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    state_d   = S_IDLE;
                    timeout_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        req_d  = (state_d == S_REQ);
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= S_IDLE;
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            deb_cnt_q    <= '0;
            trig_pulse_q <= 1'b0;
            pending_q    <= 1'b0;
            wait_cnt_q   <= '0;
            ptr_q        <= '0;
            leds_q       <= '0;
            timeout_q    <= 1'b0;
            busy_q       <= 1'b0;
            req_q        <= 1'b0;
            addr_q       <= '0;
        end else begin
            state_q      <= state_d;
            sync1_q      <= trigger;
            sync2_q      <= sync1_q;
            deb_cnt_q    <= deb_cnt_d;
            trig_pulse_q <= trig_pulse_d;
            pending_q    <= pending_d;
            wait_cnt_q   <= wait_cnt_d;
            ptr_q        <= ptr_d;
            leds_q       <= leds_d;
            timeout_q    <= timeout_d;
            busy_q       <= busy_d;
            req_q        <= req_d;
            addr_q       <= addr_d;
        end
    end

    assign bus.init_req  = req_q;
    assign bus.init_mode = 1'b0;
    assign bus.init_addr = addr_q;
    assign leds          = leds_q;
    assign busy          = busy_q;
    assign timeout_err   = timeout_q;
    assign buf_ptr       = ptr_q;

endmodule
